// File: rtl/alu_slice_pkg.sv
// Shared code enums and multiply-sequencer state for the ALU slice.
package alu_slice_pkg;

    typedef enum logic [2:0] {
        SrcAQ, SrcAB, SrcZQ, SrcZB, SrcZA, SrcDA, SrcDQ, SrcDZ
    } src_e;

    typedef enum logic [2:0] {
        OpAdd, OpSMinusR, OpRMinusS, OpOr, OpAnd, OpNotRAndS, OpXor, OpXnor
    } op_e;

    typedef enum logic [2:0] {
        DestQreg, DestNop, DestRamA, DestRamF, DestRamQd, DestRamD, DestRamQu, DestRamU
    } dest_e;

    typedef enum logic [1:0] {StIdle, StRun, StDone} mul_state_e;

endpackage

// File: rtl/alu_slice_if.sv
// Operand, control and result bundle of the ALU slice; master drives controls, slave is the slice.
interface alu_slice_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = 4
);
    logic [WIDTH-1:0] din;
    logic [SELW-1:0]  a_sel;
    logic [SELW-1:0]  b_sel;
    logic [2:0]       alu_src;
    logic [2:0]       alu_op;
    logic [2:0]       alu_dest;
    logic             cin;
    logic             ram_sin_lsb;
    logic             ram_sin_msb;
    logic             q_sin_lsb;
    logic             q_sin_msb;
    logic             flag_we;
    logic             mul_start;
    logic             ram_sout;
    logic             q_sout;
    logic [WIDTH-1:0] yout;
    logic             cout;
    logic             fzero;
    logic             fmsb;
    logic             ovr;
    logic [3:0]       status;
    logic             busy;
    logic             done;

    modport master (
        output din, a_sel, b_sel, alu_src, alu_op, alu_dest, cin,
        output ram_sin_lsb, ram_sin_msb, q_sin_lsb, q_sin_msb, flag_we, mul_start,
        input  ram_sout, q_sout, yout, cout, fzero, fmsb, ovr, status, busy, done
    );

    modport slave (
        input  din, a_sel, b_sel, alu_src, alu_op, alu_dest, cin,
        input  ram_sin_lsb, ram_sin_msb, q_sin_lsb, q_sin_msb, flag_we, mul_start,
        output ram_sout, q_sout, yout, cout, fzero, fmsb, ovr, status, busy, done
    );
endinterface

// File: rtl/alu_slice_mul_seq.sv
// Shift-and-add unsigned multiply sequencer: accumulator regs[K] holds the high half, Q the low.
module alu_slice_mul_seq
    import alu_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SELW  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [SELW-1:0]  acc_sel,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [SELW-1:0]  acc_idx,
    output logic             acc_we,
    output logic [SELW-1:0]  acc_wsel,
    output logic [WIDTH-1:0] acc_wdata,
    output logic             q_we,
    output logic [WIDTH-1:0] q_wdata
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [SELW-1:0]  k_q, k_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign acc_idx = k_q;
    assign sum     = {1'b0, acc} + (q[0] ? {1'b0, m_q} : '0);

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        acc_we    = 1'b0;
        acc_wsel  = k_q;
        acc_wdata = '0;
        q_we      = 1'b0;
        q_wdata   = q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    m_d      = mcand;
                    k_d      = acc_sel;
                    cnt_d    = CntW'(WIDTH);
                    acc_we   = 1'b1;
                    acc_wsel = acc_sel;
                    state_d  = StRun;
                end
            end
            // One partial product per cycle; the extra cycle at count 0 is the hand-off to done.
            StRun: begin
                if (cnt_q != '0) begin
                    acc_we    = 1'b1;
                    acc_wdata = sum[WIDTH:1];
                    q_we      = 1'b1;
                    q_wdata   = {sum[0], q[WIDTH-1:1]};
                    cnt_d     = cnt_q - CntW'(1);
                end else begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            m_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_slice.sv
// Bit-slice ALU with register file, Q register and status flags.
// Define ALU_SLICE_MUL_EN to include the multiply sequencer.
module alu_slice
    import alu_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 16
) (
    input logic        clock,
    input logic        reset_n,
    alu_slice_if.slave bus
);
    localparam int unsigned SELW = $clog2(NREGS);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] q_q, q_d;
    logic [3:0]       status_q;

    src_e             src;
    op_e              op;
    dest_e            dest;
    logic [WIDTH-1:0] a_data, b_data, r, s, r_op, s_op, f, y, b_wdata, q_wdata;
    logic [WIDTH:0]   sum;
    logic             arith, cout, ovr, ram_sout, q_sout, b_we, q_we;

    logic             mul_busy, mul_done, mul_acc_we, mul_q_we;
    logic [SELW-1:0]  mul_wsel;
    logic [WIDTH-1:0] mul_acc_wdata, mul_q_wdata;

    assign src    = src_e'(bus.alu_src);
    assign op     = op_e'(bus.alu_op);
    assign dest   = dest_e'(bus.alu_dest);
    assign a_data = regs_q[bus.a_sel];
    assign b_data = regs_q[bus.b_sel];

    always_comb begin
        r = '0;
        s = '0;
        unique case (src)
            SrcAQ:   begin r = a_data;  s = q_q;    end
            SrcAB:   begin r = a_data;  s = b_data; end
            SrcZQ:   s = q_q;
            SrcZB:   s = b_data;
            SrcZA:   s = a_data;
            SrcDA:   begin r = bus.din; s = a_data; end
            SrcDQ:   begin r = bus.din; s = q_q;    end
            SrcDZ:   r = bus.din;
            default: ;
        endcase
    end

    // Subtraction is addition of the inverted operand; cin supplies the +1.
    assign r_op  = (op == OpSMinusR) ? ~r : r;
    assign s_op  = (op == OpRMinusS) ? ~s : s;
    assign sum   = {1'b0, r_op} + {1'b0, s_op} + {{WIDTH{1'b0}}, bus.cin};
    assign arith = (op == OpAdd) || (op == OpSMinusR) || (op == OpRMinusS);

    always_comb begin
        f = sum[WIDTH-1:0];
        unique case (op)
            OpOr:       f = r | s;
            OpAnd:      f = r & s;
            OpNotRAndS: f = ~r & s;
            OpXor:      f = r ^ s;
            OpXnor:     f = ~(r ^ s);
            default:    ;
        endcase
    end

    assign cout = arith & sum[WIDTH];
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    assign ovr  = arith & (sum[WIDTH-1] ^ r_op[WIDTH-1] ^ s_op[WIDTH-1] ^ sum[WIDTH]);

    always_comb begin
        y        = f;
        ram_sout = 1'b0;
        q_sout   = 1'b0;
        b_we     = 1'b0;
        b_wdata  = f;
        q_we     = 1'b0;
        q_wdata  = f;
        unique case (dest)
            DestQreg: q_we = 1'b1;
            DestNop:  ;
            DestRamA: begin y = a_data; b_we = 1'b1; end
            DestRamF: b_we = 1'b1;
            DestRamQd, DestRamD: begin
                b_we     = 1'b1;
                b_wdata  = {bus.ram_sin_msb, f[WIDTH-1:1]};
                ram_sout = f[0];
                if (dest == DestRamQd) begin
                    q_we    = 1'b1;
                    q_wdata = {bus.q_sin_msb, q_q[WIDTH-1:1]};
                    q_sout  = q_q[0];
                end
            end
            DestRamQu, DestRamU: begin
                b_we     = 1'b1;
                b_wdata  = {f[WIDTH-2:0], bus.ram_sin_lsb};
                ram_sout = f[WIDTH-1];
                if (dest == DestRamQu) begin
                    q_we    = 1'b1;
                    q_wdata = {q_q[WIDTH-2:0], bus.q_sin_lsb};
                    q_sout  = q_q[WIDTH-1];
                end
            end
            default: ;
        endcase
    end

`ifdef ALU_SLICE_MUL_EN
    logic [SELW-1:0]  mul_idx;
    logic [WIDTH-1:0] mul_acc;

    assign mul_acc = regs_q[mul_idx];

    alu_slice_mul_seq #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_mul_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (bus.mul_start),
        .mcand     (a_data),
        .acc_sel   (bus.b_sel),
        .acc       (mul_acc),
        .q         (q_q),
        .busy      (mul_busy),
        .done      (mul_done),
        .acc_idx   (mul_idx),
        .acc_we    (mul_acc_we),
        .acc_wsel  (mul_wsel),
        .acc_wdata (mul_acc_wdata),
        .q_we      (mul_q_we),
        .q_wdata   (mul_q_wdata)
    );
`else
    logic unused_mul_start;

    assign unused_mul_start = bus.mul_start;
    assign mul_busy         = 1'b0;
    assign mul_done         = 1'b0;
    assign mul_acc_we       = 1'b0;
    assign mul_wsel         = '0;
    assign mul_acc_wdata    = '0;
    assign mul_q_we         = 1'b0;
    assign mul_q_wdata      = '0;
`endif

    always_comb begin
        regs_d = regs_q;
        q_d    = q_q;
        if (!mul_busy) begin
            if (b_we) regs_d[bus.b_sel] = b_wdata;
            if (q_we) q_d = q_wdata;
        end
        if (mul_acc_we) regs_d[mul_wsel] = mul_acc_wdata;
        if (mul_q_we)   q_d = mul_q_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
            q_q      <= '0;
            status_q <= '0;
        end else begin
            regs_q <= regs_d;
            q_q    <= q_d;
            if (bus.flag_we) status_q <= {ovr, f[WIDTH-1], (f == '0), cout};
        end
    end

    assign bus.yout     = y;
    assign bus.cout     = cout;
    assign bus.ovr      = ovr;
    assign bus.fzero    = (f == '0);
    assign bus.fmsb     = f[WIDTH-1];
    assign bus.ram_sout = ram_sout;
    assign bus.q_sout   = q_sout;
    assign bus.status   = status_q;
    assign bus.busy     = mul_busy;
    assign bus.done     = mul_done;

endmodule

// File: tb/tb_alu_slice.sv
// Self-checking bench for alu_slice: ALU vector table plus shift, status, multiply and reset sequences.
module tb_alu_slice;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREGS = 16;
    localparam int unsigned SELW  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    logic [15:0] sb_q [$];

    always #5 clock = ~clock;

    alu_slice_if #(.WIDTH(WIDTH), .SELW(SELW)) bus ();

    alu_slice #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // {cout, fzero, fmsb, ovr, ram_sout, q_sout}
    typedef struct {
        logic [2:0] src;
        logic [2:0] op;
        logic [2:0] dest;
        logic [7:0] din;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [7:0] y;
        logic [5:0] fl;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.din         = '0;
        bus.a_sel       = '0;
        bus.b_sel       = '0;
        bus.alu_src     = 3'd3;
        bus.alu_op      = 3'd3;
        bus.alu_dest    = 3'd1;
        bus.cin         = 1'b0;
        bus.ram_sin_lsb = 1'b0;
        bus.ram_sin_msb = 1'b0;
        bus.q_sin_lsb   = 1'b0;
        bus.q_sin_msb   = 1'b0;
        bus.flag_we     = 1'b0;
        bus.mul_start   = 1'b0;
    endtask

    task automatic drive(input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest,
                         input logic [7:0] din, input logic [3:0] a, input logic [3:0] b,
                         input logic cin);
        bus.alu_src  = src;
        bus.alu_op   = op;
        bus.alu_dest = dest;
        bus.din      = din;
        bus.a_sel    = a;
        bus.b_sel    = b;
        bus.cin      = cin;
    endtask

    task automatic wr_reg(input logic [3:0] k, input logic [7:0] v);
        @(negedge clock);
        drive(3'd7, 3'd0, 3'd3, v, 4'd0, k, 1'b0);
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic wr_q(input logic [7:0] v);
        @(negedge clock);
        drive(3'd7, 3'd0, 3'd0, v, 4'd0, 4'd0, 1'b0);
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic read_reg(input logic [3:0] k, output logic [7:0] v);
        drive(3'd1, 3'd3, 3'd1, 8'h00, k, k, 1'b0);
        #1;
        v = bus.yout;
    endtask

    task automatic read_q(output logic [7:0] v);
        drive(3'd2, 3'd3, 3'd1, 8'h00, 4'd0, 4'd0, 1'b0);
        #1;
        v = bus.yout;
    endtask

    // Starts a multiply, optionally injects writes and mul_start while it runs, and times done.
    task automatic run_mul(input logic [3:0] a, input logic [3:0] k, input bit inject,
                           output int done_cyc, output int busy_cycles);
        done_cyc    = -1;
        busy_cycles = 0;
        @(negedge clock);
        idle();
        bus.a_sel     = a;
        bus.b_sel     = k;
        bus.mul_start = 1'b1;
        @(posedge clock);
        #1;
        bus.mul_start = 1'b0;
        if (bus.busy) busy_cycles++;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (inject && cyc == 2) begin
                drive(3'd7, 3'd0, 3'd3, 8'h55, 4'd0, k, 1'b0);
                bus.mul_start = 1'b1;
                #1;
                chk("busy_comb_yout", 32'(bus.yout), 32'h55);
            end
            if (inject && cyc == 3) bus.alu_dest = 3'd0;
            if (inject && cyc == 4) idle();
            @(posedge clock);
            #1;
            if (bus.busy) busy_cycles++;
            if (bus.done && done_cyc < 0) done_cyc = cyc;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]  v;
        logic [15:0] exp;
        int          done_cyc;
        int          busy_cycles;

        vecs[0]  = '{3'd3, 3'd0, 3'd1, 8'h00, 4'd0, 4'd1, 1'b1, 8'h00, 6'b110000};
        vecs[1]  = '{3'd1, 3'd0, 3'd1, 8'h00, 4'd7, 4'd8, 1'b0, 8'hE1, 6'b001000};
        vecs[2]  = '{3'd1, 3'd1, 3'd1, 8'h00, 4'd7, 4'd8, 1'b1, 8'h69, 6'b100100};
        vecs[3]  = '{3'd1, 3'd2, 3'd1, 8'h00, 4'd7, 4'd8, 1'b1, 8'h97, 6'b001100};
        vecs[4]  = '{3'd5, 3'd3, 3'd1, 8'h50, 4'd4, 4'd0, 1'b0, 8'h5B, 6'b000000};
        vecs[5]  = '{3'd6, 3'd4, 3'd1, 8'h0F, 4'd0, 4'd0, 1'b0, 8'h0D, 6'b000000};
        vecs[6]  = '{3'd4, 3'd5, 3'd1, 8'h00, 4'd8, 4'd0, 1'b0, 8'hA5, 6'b001000};
        vecs[7]  = '{3'd0, 3'd6, 3'd1, 8'h00, 4'd7, 4'd0, 1'b0, 8'h31, 6'b000000};
        vecs[8]  = '{3'd2, 3'd7, 3'd1, 8'h00, 4'd0, 4'd0, 1'b0, 8'hF2, 6'b001000};
        vecs[9]  = '{3'd1, 3'd7, 3'd1, 8'h00, 4'd3, 4'd3, 1'b0, 8'hFF, 6'b001000};
        vecs[10] = '{3'd1, 3'd4, 3'd2, 8'h00, 4'd8, 4'd7, 1'b0, 8'hA5, 6'b000000};
        vecs[11] = '{3'd3, 3'd3, 3'd5, 8'h00, 4'd0, 4'd3, 1'b0, 8'h81, 6'b001010};
        vecs[12] = '{3'd3, 3'd3, 3'd4, 8'h00, 4'd0, 4'd8, 1'b0, 8'hA5, 6'b001011};
        vecs[13] = '{3'd3, 3'd3, 3'd6, 8'h00, 4'd0, 4'd8, 1'b0, 8'hA5, 6'b001010};
        vecs[14] = '{3'd3, 3'd3, 3'd7, 8'h00, 4'd0, 4'd3, 1'b0, 8'h81, 6'b001010};
        vecs[15] = '{3'd7, 3'd2, 3'd0, 8'h10, 4'd0, 4'd0, 1'b1, 8'h10, 6'b100000};

        // Reset state
        idle();
        #3;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_status", 32'(bus.status), 32'd0);
        read_reg(4'd1, v);
        chk("rst_reg1", 32'(v), 32'h00);
        @(negedge clock);
        reset_n = 1'b1;

        wr_reg(4'd1, 8'hFF);
        wr_reg(4'd3, 8'h81);
        wr_reg(4'd4, 8'h0B);
        wr_reg(4'd7, 8'h3C);
        wr_reg(4'd8, 8'hA5);
        wr_q(8'h0D);

        // Combinational vectors; dest returns to no-write before each edge
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            drive(vecs[i].src, vecs[i].op, vecs[i].dest, vecs[i].din, vecs[i].a, vecs[i].b,
                  vecs[i].cin);
            sb_q.push_back({vecs[i].y, 2'b00, vecs[i].fl});
            #1;
            exp = sb_q.pop_front();
            chk($sformatf("vec%0d_yout", i), 32'(bus.yout), 32'(exp[15:8]));
            chk($sformatf("vec%0d_flags", i),
                32'({bus.cout, bus.fzero, bus.fmsb, bus.ovr, bus.ram_sout, bus.q_sout}),
                32'(exp[5:0]));
            idle();
        end

        // Overflow into MSB, written back to B
        @(negedge clock);
        drive(3'd7, 3'd0, 3'd3, 8'h7F, 4'd0, 4'd2, 1'b1);
        #1;
        chk("ovf_yout", 32'(bus.yout), 32'h80);
        chk("ovf_flags", 32'({bus.ovr, bus.fmsb, bus.cout}), 32'b110);
        @(posedge clock);
        #1;
        idle();
        read_reg(4'd2, v);
        chk("ovf_reg2", 32'(v), 32'h80);

        // Right shift of B and Q with fills
        wr_q(8'h01);
        @(negedge clock);
        drive(3'd3, 3'd3, 3'd4, 8'h00, 4'd0, 4'd3, 1'b0);
        bus.ram_sin_msb = 1'b1;
        bus.q_sin_msb   = 1'b0;
        #1;
        chk("shr_souts", 32'({bus.ram_sout, bus.q_sout}), 32'b11);
        @(posedge clock);
        #1;
        idle();
        read_reg(4'd3, v);
        chk("shr_reg3", 32'(v), 32'hC0);
        read_q(v);
        chk("shr_q", 32'(v), 32'h00);

        // Left shift of B and Q with LSB fills
        @(negedge clock);
        drive(3'd3, 3'd3, 3'd6, 8'h00, 4'd0, 4'd7, 1'b0);
        bus.ram_sin_lsb = 1'b1;
        bus.q_sin_lsb   = 1'b1;
        @(posedge clock);
        #1;
        idle();
        read_reg(4'd7, v);
        chk("shl_reg7", 32'(v), 32'h79);
        read_q(v);
        chk("shl_q", 32'(v), 32'h01);

        // Status load and hold
        @(negedge clock);
        drive(3'd3, 3'd0, 3'd1, 8'h00, 4'd0, 4'd1, 1'b1);
        bus.flag_we = 1'b1;
        @(posedge clock);
        #1;
        idle();
        chk("status_load", 32'(bus.status), 32'h3);
        @(negedge clock);
        drive(3'd1, 3'd0, 3'd1, 8'h00, 4'd7, 4'd8, 1'b0);
        @(posedge clock);
        #1;
        chk("status_hold", 32'(bus.status), 32'h3);
        @(negedge clock);
        drive(3'd7, 3'd0, 3'd1, 8'h7F, 4'd0, 4'd0, 1'b1);
        bus.flag_we = 1'b1;
        @(posedge clock);
        #1;
        idle();
        chk("status_reload", 32'(bus.status), 32'hC);

        // Multiply 0x0B * 0x0D into K=5
        wr_q(8'h0D);
        wr_reg(4'd5, 8'h77);
`ifdef ALU_SLICE_MUL_EN
        sb_q.push_back(16'h008F);
`else
        sb_q.push_back(16'h770D);
`endif
        run_mul(4'd4, 4'd5, 1'b0, done_cyc, busy_cycles);
`ifdef ALU_SLICE_MUL_EN
        chk("mul1_done_cycle", 32'(done_cyc), 32'd9);
        chk("mul1_busy_cycles", 32'(busy_cycles), 32'd10);
`else
        chk("mul1_done_cycle", 32'(done_cyc), 32'hFFFF_FFFF);
        chk("mul1_busy_cycles", 32'(busy_cycles), 32'd0);
`endif
        exp = sb_q.pop_front();
        read_reg(4'd5, v);
        chk("mul1_hi", 32'(v), 32'(exp[15:8]));
        read_q(v);
        chk("mul1_lo", 32'(v), 32'(exp[7:0]));

        // Multiply 0xFF * 0xFF into K=6 with writes and mul_start attempted while busy
        wr_reg(4'd0, 8'hFF);
        wr_q(8'hFF);
        wr_reg(4'd6, 8'h12);
`ifdef ALU_SLICE_MUL_EN
        sb_q.push_back(16'hFE01);
`else
        sb_q.push_back(16'h5555);
`endif
        run_mul(4'd0, 4'd6, 1'b1, done_cyc, busy_cycles);
`ifdef ALU_SLICE_MUL_EN
        chk("mul2_done_cycle", 32'(done_cyc), 32'd9);
        chk("mul2_busy_cycles", 32'(busy_cycles), 32'd10);
`else
        chk("mul2_done_cycle", 32'(done_cyc), 32'hFFFF_FFFF);
        chk("mul2_busy_cycles", 32'(busy_cycles), 32'd0);
`endif
        exp = sb_q.pop_front();
        read_reg(4'd6, v);
        chk("mul2_hi", 32'(v), 32'(exp[15:8]));
        read_q(v);
        chk("mul2_lo", 32'(v), 32'(exp[7:0]));

        // Reset in the middle of a multiply
        @(negedge clock);
        idle();
        bus.a_sel     = 4'd4;
        bus.b_sel     = 4'd5;
        bus.mul_start = 1'b1;
        @(posedge clock);
        #1;
        bus.mul_start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
`ifdef ALU_SLICE_MUL_EN
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
`endif
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_status", 32'(bus.status), 32'd0);
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            read_reg(4'(k), v);
            chk($sformatf("abort_reg%0d", k), 32'(v), 32'h00);
        end
        read_q(v);
        chk("abort_q", 32'(v), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_slice.md
ALU_SLICE -- requirements
Module: alu_slice

Interface
REQ-001 Parameter WIDTH, default 8, datapath width in bits (legal 4..32).
REQ-002 Parameter NREGS, default 16, register-file depth (power of two, 2..64); SELW = log2(NREGS).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 din  input  WIDTH  external data operand D.
REQ-006 a_sel, b_sel  input  SELW each  register-file A and B addresses.
REQ-007 alu_src, alu_op, alu_dest  input  3 each  source, function and destination codes.
REQ-008 cin  input  1  carry in.
REQ-009 ram_sin_lsb, ram_sin_msb, q_sin_lsb, q_sin_msb  input  1 each  shift fill bits.
REQ-010 ram_sout, q_sout  output  1 each  bit shifted out of F and Q (0 when no shift).
REQ-011 yout  output  WIDTH  Y result.
REQ-012 cout, fzero, fmsb, ovr  output  1 each  combinational flags of current F.
REQ-013 flag_we  input  1; status  output  4  registered {ovr,fmsb,fzero,cout}.
REQ-014 mul_start  input  1; busy, done  output  1 each  multiply sequencer handshake.

Function
REQ-015 Source codes (R,S): 0 A,Q; 1 A,B; 2 0,Q; 3 0,B; 4 0,A; 5 D,A; 6 D,Q; 7 D,0.
REQ-016 Ops: 0 R+S+cin; 1 S+~R+cin; 2 R+~S+cin; 3 R|S; 4 R&S; 5 ~R&S; 6 R^S; 7 ~(R^S); arithmetic is WIDTH+1 bits.
REQ-017 cout = bit WIDTH of sum for ops 0-2, 0 for ops 3-7; ovr = carry into MSB XOR cout for ops 0-2, 0 otherwise.
REQ-018 fzero = (F==0); fmsb = F[WIDTH-1]; all flags combinational, same cycle.
REQ-019 Dest: 0 Y=F,Q<=F; 1 Y=F, no write; 2 Y=A,B<=F; 3 Y=F,B<=F; 4 B<=F>>1,Q<=Q>>1; 5 B<=F>>1; 6 B<=F<<1,Q<=Q<<1; 7 B<=F<<1; Y=F for 3-7.
REQ-020 Right shifts fill MSB with ram_sin_msb/q_sin_msb and drive F[0]/Q[0] on ram_sout/q_sout; left shifts fill LSB with ram_sin_lsb/q_sin_lsb and drive F[MSB]/Q[MSB].
REQ-021 Register and Q writes occur on rising clock; reads are combinational (write-then-read next cycle).
REQ-022 status loads {ovr,fmsb,fzero,cout} on clock when flag_we=1, else holds.
REQ-023 Multiply FSM states IDLE, RUN, DONE; busy = (state != IDLE); done = (state == DONE).
REQ-024 IDLE: mul_start=1 captures multiplicand M = regs[a_sel], latches accumulator index K = b_sel, writes regs[K] <= 0, loads step counter = WIDTH, goes RUN.
REQ-025 RUN each cycle: sum = regs[K] + (Q[0] ? M : 0) (WIDTH+1 bits); {regs[K],Q} <= {sum,Q} >> 1; counter decrements; counter reaching 0 -> DONE.
REQ-026 DONE lasts exactly one cycle then IDLE; product unsigned, high half in regs[K], low half in Q; done is high WIDTH+1 cycles after the start edge.
REQ-027 While busy: external register/Q writes and mul_start are ignored; combinational outputs still reflect inputs; flag_we still honoured.
REQ-028 a_sel==b_sel is legal; simultaneous shift dest codes update B and Q in the same edge.

Reset
REQ-029 reset_n low asynchronously clears all registers, Q, status, M, K, counter; FSM to IDLE; busy=0, done=0.
REQ-030 Reset during RUN aborts multiply; no partial result survives.

Configuration
REQ-031 ALU_SLICE_MUL_EN defined: multiply sequencer present as specified.
REQ-032 ALU_SLICE_MUL_EN undefined: sequencer absent; mul_start ignored; busy and done tied 0; all other behaviour identical.

Structure
REQ-033 Package alu_slice_pkg holds src/op/dest code enums and FSM state typedef.
REQ-034 Multiply FSM is one sub-module, alu_slice_mul_seq; register file and ALU stay in alu_slice.

Verification (WIDTH=8, NREGS=16)
REQ-035 src=7,op=0,dest=3,din=0x7F,b_sel=2,cin=1 -> yout=0x80, ovr=1, fmsb=1, cout=0; next cycle regs[2]=0x80.
REQ-036 regs[1]=0xFF,src=3,op=0,dest=1,b_sel=1,cin=1 -> yout=0x00, cout=1, fzero=1, ovr=0.
REQ-037 Q=0x01,regs[3]=0x81,src=3,op=3,dest=4,ram_sin_msb=1,q_sin_msb=0 -> regs[3]=0xC0, Q=0x00, ram_sout=1, q_sout=1.
REQ-038 Q=0x0D,regs[4]=0x0B,a_sel=4,b_sel=5,mul_start -> busy next cycle, done 9 cycles after start edge, regs[5]=0x00, Q=0x8F.
REQ-039 Q=0xFF,regs[0]=0xFF, multiply into K=6 -> regs[6]=0xFE, Q=0x01; mul_start and dest=3 writes during busy have no effect.
REQ-040 reset_n low at RUN cycle 4 -> busy=0 immediately, all registers and Q read 0, status=0.
